// File: rtl/park_pkg.sv
// Shared types and constants for the parking zone controller.
// Phase encodings are fixed so the 2-bit phase port can be decoded outside the block.
package park_pkg;
   localparam int HOURS_PER_DAY = 24;

   typedef enum logic [1:0] {
      PH_NIGHT    = 2'd0,
      PH_RESERVED = 2'd1,
      PH_RELEASE  = 2'd2,
      PH_OPEN     = 2'd3
   } phase_t;
endpackage

// File: rtl/park_capacity_sched.sv
// Hour-of-day schedule: registers phase and uni-pool reservation from the hour input.
// An out-of-range hour raises hour_err and freezes the last valid phase and caps.
module park_capacity_sched
   import park_pkg::*;
#(
   parameter int CNT_W        = 10,
   parameter int TOTAL_CAP    = 700,
   parameter int UNI_CAP_MAX  = 500,
   parameter int UNI_CAP_MIN  = 200,
   parameter int OPEN_HOUR    = 8,
   parameter int RELEASE_HOUR = 13,
   parameter int RELEASE_END  = 16,
   parameter int RELEASE_STEP = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       hour,
   output phase_t           phase,
   output logic [CNT_W-1:0] uni_cap,
   output logic [CNT_W-1:0] gen_cap,
   output logic             hour_err
);
   localparam logic [4:0] OPEN_H = 5'(OPEN_HOUR);
   localparam logic [4:0] REL_H  = 5'(RELEASE_HOUR);
   localparam logic [4:0] END_H  = 5'(RELEASE_END);
   localparam logic [4:0] DAY_H  = 5'(HOURS_PER_DAY);

   phase_t           phase_p1, phase_nxt;
   logic [CNT_W-1:0] uni_cap_p1, uni_cap_nxt;
   logic             hour_err_p1;

   // Linear hourly release, floored at the minimum reservation.
   function automatic logic [CNT_W-1:0] release_cap(input logic [4:0] h);
      logic signed [31:0] c;
      c = UNI_CAP_MAX - RELEASE_STEP * (int'(h) - RELEASE_HOUR);
      if (c < UNI_CAP_MIN) c = UNI_CAP_MIN;
      return CNT_W'(c);
   endfunction

   always_comb begin
      phase_nxt   = PH_OPEN;
      uni_cap_nxt = CNT_W'(UNI_CAP_MIN);
      if (hour < OPEN_H) begin
         phase_nxt   = PH_NIGHT;
      end else if (hour < REL_H) begin
         phase_nxt   = PH_RESERVED;
         uni_cap_nxt = CNT_W'(UNI_CAP_MAX);
      end else if (hour < END_H) begin
         phase_nxt   = PH_RELEASE;
         uni_cap_nxt = release_cap(hour);
      end
   end

   // Stage p1: registered schedule
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_p1    <= PH_NIGHT;
         uni_cap_p1  <= CNT_W'(UNI_CAP_MIN);
         hour_err_p1 <= 1'b0;
      end else if (hour >= DAY_H) begin
         hour_err_p1 <= 1'b1;
      end else begin
         phase_p1    <= phase_nxt;
         uni_cap_p1  <= uni_cap_nxt;
         hour_err_p1 <= 1'b0;
      end
   end

   assign phase    = phase_p1;
   assign uni_cap  = uni_cap_p1;
   assign gen_cap  = CNT_W'(TOTAL_CAP) - uni_cap_p1;
   assign hour_err = hour_err_p1;
endmodule

// File: rtl/park_zone_ctrl.sv
// Parking zone controller: judges entry/exit requests against the scheduled caps,
// keeps uni, general and uni-overflow occupancy, and reports free space per pool.
module park_zone_ctrl
   import park_pkg::*;
#(
   parameter int CNT_W        = 10,
   parameter int TOTAL_CAP    = 700,
   parameter int UNI_CAP_MAX  = 500,
   parameter int UNI_CAP_MIN  = 200,
   parameter int OPEN_HOUR    = 8,
   parameter int RELEASE_HOUR = 13,
   parameter int RELEASE_END  = 16,
   parameter int RELEASE_STEP = 100,
   parameter bit UNI_OVERFLOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       hour,
   input  logic             car_entered,
   input  logic             is_uni_car_entered,
   input  logic             car_exited,
   input  logic             is_uni_car_exited,
   output logic             entry_grant,
   output logic             entry_deny,
   output logic             exit_err,
   output logic             hour_err,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] uni_parked_car,
   output logic [CNT_W-1:0] parked_car,
   output logic [CNT_W-1:0] uni_vacated_space,
   output logic [CNT_W-1:0] vacated_space,
   output logic             uni_is_vacated_space,
   output logic             is_vacated_space,
   output logic             parking_is_vacated_space
);
   phase_t           phase_s;
   logic [CNT_W-1:0] uni_cap, gen_cap;
   logic [CNT_W-1:0] uni_cnt_p1, gen_cnt_p1, ovf_cnt_p1;
   logic             grant_p1, deny_p1, xerr_p1;
   logic             uni_inc, gen_inc, ovf_inc, uni_dec, gen_dec, ovf_dec;
   logic             grant, deny, xerr;
   logic             uni_room, gen_room;

   park_capacity_sched #(
      .CNT_W(CNT_W), .TOTAL_CAP(TOTAL_CAP), .UNI_CAP_MAX(UNI_CAP_MAX),
      .UNI_CAP_MIN(UNI_CAP_MIN), .OPEN_HOUR(OPEN_HOUR), .RELEASE_HOUR(RELEASE_HOUR),
      .RELEASE_END(RELEASE_END), .RELEASE_STEP(RELEASE_STEP)
   ) u_sched (
      .clk(clk), .rst(rst), .hour(hour),
      .phase(phase_s), .uni_cap(uni_cap), .gen_cap(gen_cap), .hour_err(hour_err)
   );

   // Room is judged on pre-exit occupancy, so an exit never admits a same-cycle entry.
   assign uni_room = uni_cnt_p1 < uni_cap;
   assign gen_room = gen_cnt_p1 < gen_cap;

   always_comb begin
      uni_inc = 1'b0; gen_inc = 1'b0; ovf_inc = 1'b0;
      uni_dec = 1'b0; gen_dec = 1'b0; ovf_dec = 1'b0;
      grant   = 1'b0; deny    = 1'b0; xerr    = 1'b0;
      if (car_entered) begin
         if (is_uni_car_entered && uni_room) begin
            uni_inc = 1'b1;
         end else if (gen_room && (!is_uni_car_entered || UNI_OVERFLOW)) begin
            gen_inc = 1'b1;
            ovf_inc = is_uni_car_entered;
         end
         grant = uni_inc | gen_inc;
         deny  = ~grant;
      end
      if (car_exited) begin
         if (is_uni_car_exited) begin
            if (ovf_cnt_p1 != '0) begin
               gen_dec = 1'b1;
               ovf_dec = 1'b1;
            end else if (uni_cnt_p1 != '0) begin
               uni_dec = 1'b1;
            end else begin
               xerr = 1'b1;
            end
         end else if (gen_cnt_p1 > ovf_cnt_p1) begin
            gen_dec = 1'b1;
         end else begin
            xerr = 1'b1;
         end
      end
   end

   // Stage p1: occupancy counters and result pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         uni_cnt_p1 <= '0;
         gen_cnt_p1 <= '0;
         ovf_cnt_p1 <= '0;
         grant_p1   <= 1'b0;
         deny_p1    <= 1'b0;
         xerr_p1    <= 1'b0;
      end else begin
         uni_cnt_p1 <= uni_cnt_p1 + CNT_W'(uni_inc) - CNT_W'(uni_dec);
         gen_cnt_p1 <= gen_cnt_p1 + CNT_W'(gen_inc) - CNT_W'(gen_dec);
         ovf_cnt_p1 <= ovf_cnt_p1 + CNT_W'(ovf_inc) - CNT_W'(ovf_dec);
         grant_p1   <= grant;
         deny_p1    <= deny;
         xerr_p1    <= xerr;
      end
   end

   assign entry_grant              = grant_p1;
   assign entry_deny               = deny_p1;
   assign exit_err                 = xerr_p1;
   assign phase                    = phase_s;
   assign uni_parked_car           = uni_cnt_p1;
   assign parked_car               = gen_cnt_p1;
   assign uni_vacated_space        = uni_room ? (uni_cap - uni_cnt_p1) : '0;
   assign vacated_space            = gen_room ? (gen_cap - gen_cnt_p1) : '0;
   assign uni_is_vacated_space     = uni_room;
   assign is_vacated_space         = gen_room;
   assign parking_is_vacated_space = uni_room | gen_room;
endmodule

// File: tb/tb_park_zone_ctrl.sv
// Self-checking bench for park_zone_ctrl: an independent occupancy/schedule model
// queues expected pulses per request and compares them one cycle later.
module tb_park_zone_ctrl;
   localparam int CNT_W = 10;
   localparam int TOTAL = 700;

   typedef struct packed {
      logic g;
      logic d;
      logic x;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [4:0]       hour = 5'd0;
   logic             car_entered = 1'b0, is_uni_car_entered = 1'b0;
   logic             car_exited = 1'b0, is_uni_car_exited = 1'b0;
   logic             entry_grant, entry_deny, exit_err, hour_err;
   logic [1:0]       phase;
   logic [CNT_W-1:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
   logic             uni_is_vacated_space, is_vacated_space, parking_is_vacated_space;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   int m_uni = 0, m_gen = 0, m_ovf = 0, m_ucap = 200, m_phase = 0, m_herr = 0;

   park_zone_ctrl dut (
      .clk(clk), .rst(rst), .hour(hour),
      .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
      .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
      .entry_grant(entry_grant), .entry_deny(entry_deny), .exit_err(exit_err),
      .hour_err(hour_err), .phase(phase),
      .uni_parked_car(uni_parked_car), .parked_car(parked_car),
      .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
      .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
      .parking_is_vacated_space(parking_is_vacated_space)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int cap_tab(input int h);
      if (h < 8)   return 200;
      if (h < 14)  return 500;
      if (h == 14) return 400;
      if (h == 15) return 300;
      return 200;
   endfunction

   function automatic int phase_tab(input int h);
      if (h < 8)  return 0;
      if (h < 13) return 1;
      if (h < 16) return 2;
      return 3;
   endfunction

   // One clock: predict from model state and driven inputs, advance, compare.
   task automatic tick();
      exp_t e;
      int   du, dg, dov, gcap, h;
      logic r;
      du = 0; dg = 0; dov = 0; e = '0;
      gcap = TOTAL - m_ucap;
      r = rst;
      h = int'(hour);
      if (!r) begin
         if (car_entered) begin
            if (is_uni_car_entered && m_uni < m_ucap) begin
               du = 1; e.g = 1'b1;
            end else if (m_gen < gcap) begin
               dg = 1; e.g = 1'b1;
               if (is_uni_car_entered) dov = 1;
            end else begin
               e.d = 1'b1;
            end
         end
         if (car_exited) begin
            if (is_uni_car_exited) begin
               if (m_ovf > 0) begin dg -= 1; dov -= 1; end
               else if (m_uni > 0) du -= 1;
               else e.x = 1'b1;
            end else if (m_gen - m_ovf > 0) begin
               dg -= 1;
            end else begin
               e.x = 1'b1;
            end
         end
         if (car_entered || car_exited) sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (r) begin
         m_uni = 0; m_gen = 0; m_ovf = 0; m_ucap = 200; m_phase = 0; m_herr = 0;
      end else begin
         m_uni += du; m_gen += dg; m_ovf += dov;
         if (h > 23) m_herr = 1;
         else begin
            m_herr = 0; m_ucap = cap_tab(h); m_phase = phase_tab(h);
         end
      end
      car_entered = 1'b0;
      car_exited  = 1'b0;
      e = (sb.size() > 0) ? sb.pop_front() : exp_t'(3'b000);
      chk("grant", entry_grant, e.g);
      chk("deny", entry_deny, e.d);
      chk("exit_err", exit_err, e.x);
      chk("uni_parked", uni_parked_car, m_uni);
      chk("parked", parked_car, m_gen);
      chk("phase", phase, m_phase);
      chk("hour_err", hour_err, m_herr);
      chk("uni_vac", uni_vacated_space, (m_ucap > m_uni) ? m_ucap - m_uni : 0);
      chk("gen_vac", vacated_space, (TOTAL - m_ucap > m_gen) ? TOTAL - m_ucap - m_gen : 0);
   endtask

   task automatic req(input logic ent, input logic eu, input logic ex, input logic xu);
      car_entered = ent; is_uni_car_entered = eu;
      car_exited  = ex;  is_uni_car_exited  = xu;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_phase", phase, 0);
      chk("rst_uni_vac", uni_vacated_space, 200);
      chk("rst_gen_vac", vacated_space, 500);

      hour = 5'd9;
      tick();
      chk("h9_phase", phase, 1);
      chk("h9_uni_vac", uni_vacated_space, 500);
      chk("h9_gen_vac", vacated_space, 200);

      for (int i = 0; i < 200; i++) req(1'b1, 1'b0, 1'b0, 1'b0);
      chk("gen_full_vac", vacated_space, 0);
      chk("gen_full_flag", is_vacated_space, 0);
      req(1'b1, 1'b0, 1'b0, 1'b0);
      chk("gen_201_deny", entry_deny, 1);
      chk("gen_201_cnt", parked_car, 200);

      req(1'b1, 1'b0, 1'b1, 1'b0);
      chk("simul_deny", entry_deny, 1);
      chk("simul_vac", vacated_space, 1);

      for (int i = 0; i < 450; i++) req(1'b1, 1'b1, 1'b0, 1'b0);
      hour = 5'd14;
      tick();
      chk("h14_uni_vac", uni_vacated_space, 0);
      chk("h14_uni_flag", uni_is_vacated_space, 0);
      chk("h14_any_flag", parking_is_vacated_space, 1);

      req(1'b1, 1'b1, 1'b0, 1'b0);
      chk("ovf_grant", entry_grant, 1);
      chk("ovf_parked", parked_car, 200);
      chk("ovf_uni", uni_parked_car, 450);
      req(1'b0, 1'b0, 1'b1, 1'b1);
      chk("ovf_exit_parked", parked_car, 199);
      chk("ovf_exit_uni", uni_parked_car, 450);
      req(1'b0, 1'b0, 1'b1, 1'b1);
      chk("uni_exit", uni_parked_car, 449);

      for (int i = 0; i < 199; i++) req(1'b0, 1'b0, 1'b1, 1'b0);
      req(1'b0, 1'b0, 1'b1, 1'b0);
      chk("empty_exit_err", exit_err, 1);
      chk("empty_exit_cnt", parked_car, 0);

      hour = 5'd25;
      tick();
      chk("h25_err", hour_err, 1);
      chk("h25_phase", phase, 2);

      for (int i = 0; i < 300; i++) begin
         if (i % 20 == 0) hour = 5'($urandom_range(0, 23));
         req(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)));
      end

      hour = 5'd10;
      tick();
      rst = 1'b1;
      car_entered = 1'b1; is_uni_car_entered = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_mid_grant", entry_grant, 0);
      chk("rst_mid_parked", parked_car, 0);
      chk("rst_mid_uni", uni_parked_car, 0);
      chk("rst_mid_phase", phase, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
